servo_pwm_decoder: RTL and testbench
====================================

# servo_pwm_decoder

Measures an incoming hobby-servo PWM waveform and recovers the 0-100 duty code that produced it. It is the receive-side counterpart of the servo PWM generator, using the same 0.5 ms to 2.5 ms pulse mapping and 50 Hz frame. It sits between an off-chip servo-signal pin and the wheel controller, and is used both for loopback self-test and for monitoring an external servo driver.

## Interface
- SYS_FREQ, 100: system clock in MHz
- PULSE_FREQ, 50: nominal frame rate in Hz
- MIN_PULSE_US, 500: pulse width that maps to duty 0
- MAX_PULSE_US, 2500: pulse width that maps to duty 100

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- pwm_in  in  1  asynchronous servo PWM input
- duty_cycle  out  7  last valid decoded duty, 0-100
- duty_valid  out  1  one-cycle strobe when duty_cycle updates
- pulse_err  out  1  one-cycle strobe when a frame is rejected
- signal_lost  out  1  level; no usable frames are arriving

## Operation
- Derived constants:
  - PERIOD = SYS_FREQ*1e6/PULSE_FREQ
  - MINW = SYS_FREQ*MIN_PULSE_US
  - MAXW = SYS_FREQ*MAX_PULSE_US
  - RANGE = MAXW-MINW
  - LOST = 2*PERIOD
  - Counters are $clog2(LOST+1) bits wide.
- pwm_in passes through a 2-flop synchronizer and a registered edge detector. A rise or fall is flagged in cycle E.
- FSM states:
  - IDLE: wait for a rise, then clear the counter and go to HIGH.
  - HIGH: count high cycles. On a fall, latch the width and go to LOW.
  - LOW: keep counting total period cycles. On a rise, evaluate the frame, restart counting from 1, and return to HIGH.
- The counter counts every cycle. At a rise the width equals the number of high cycles and the period equals the number of cycles rise-to-rise.
- Frame checks at the closing rise:
  - The period must lie in [PERIOD-PERIOD/8, PERIOD+PERIOD/8].
  - The width must lie in [MINW, MAXW].
- If either check fails: pulse_err strobes in cycle E+1 and duty_cycle is held.
- If both checks pass, an independent divider converts the width:
  - Numerator = (width-MINW)*100 + RANGE/2; the divisor is RANGE.
  - Restoring division, one quotient bit per cycle, MSB first, 7 iterations.
  - The result is rounded to nearest, with halves rounding up.
- The divider runs concurrently with measurement of the next frame. A new request cannot arrive within 7 cycles, so no collision handling is needed.
- Loss of signal:
  - The counter reaching LOST in HIGH or LOW (stuck high or stuck low) sets signal_lost, drops the FSM to IDLE, and emits no strobe.
  - In IDLE, signal_lost stays set.
  - signal_lost clears in the cycle duty_valid pulses.
- The first partial frame after reset or after loss is never decoded. The first output needs two rises.

## Timing
- Reset values:
  - duty_cycle=0, duty_valid=0, pulse_err=0, signal_lost=1
  - FSM=IDLE, divider idle, synchronizer flops=0
- Reset mid-frame or mid-division discards all state immediately.
- Input to edge flag: 3 clk (2 sync + 1 detect).
- A closing rise in cycle E gives:
  - the divider busy E+1..E+7
  - duty_cycle updated, duty_valid=1, and signal_lost=0 in E+8, for exactly one cycle
- pulse_err comes 1 cycle after E.
- duty_valid and pulse_err are never high together.
- Glitches shorter than 1 clk after the synchronizer are not filtered. They are reported through the period/width checks.

## Configuration
- SERVO_DEC_CLAMP_EN defined:
  - A frame with a valid period but width < MINW decodes to 0, with duty_valid.
  - Width > MAXW decodes to 100, with duty_valid.
  - Only period violations raise pulse_err.
- Undefined: out-of-range widths raise pulse_err and hold duty_cycle.

## Test plan
- Default parameters, frames of 150000 high / 2000000 period, repeated: after the second rise, duty_cycle=50 with duty_valid at E+8; one strobe per frame thereafter.
- Widths 50000, 250000, 51000, 50999 (period 2000000): duty_cycle 0, 100, 1, 0 respectively.
- Width 40000, period 2000000:
  - Without the macro: pulse_err at E+1, duty_cycle holds its prior 50.
  - With SERVO_DEC_CLAMP_EN: duty_cycle=0 with duty_valid.
- Width 150000, period 1500000 then 2300000: pulse_err each frame, no duty_valid, regardless of the macro.
- pwm_in held low after a valid frame: signal_lost rises 4000000 cycles after the last rise. Held high from a rise: the same at 4000000. A following valid 2-rise sequence clears it at E+8.
- Assert reset during HIGH and during division: all outputs at reset values the next cycle, signal_lost=1, no late duty_valid after release.

Source files
------------

// File: rtl/servo_pwm_decoder.sv
// Servo PWM receiver: measures 50 Hz hobby-servo frames and recovers the 0-100 duty code.
// Define SERVO_DEC_CLAMP_EN to clamp out-of-range widths to 0/100 instead of rejecting them.
module servo_pwm_decoder #(
    parameter int SYS_FREQ     = 100,
    parameter int PULSE_FREQ   = 50,
    parameter int MIN_PULSE_US = 500,
    parameter int MAX_PULSE_US = 2500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pwm_in,
    output logic [6:0] duty_cycle,
    output logic       duty_valid,
    output logic       pulse_err,
    output logic       signal_lost
);

    localparam int PERIOD = SYS_FREQ * 1000000 / PULSE_FREQ;
    localparam int MINW   = SYS_FREQ * MIN_PULSE_US;
    localparam int MAXW   = SYS_FREQ * MAX_PULSE_US;
    localparam int RANGE  = MAXW - MINW;
    localparam int LOST   = 2 * PERIOD;
    localparam int CW     = $clog2(LOST + 1);
    localparam int NW     = $clog2(RANGE) + 8;

    localparam logic [CW-1:0] PLO_C   = CW'(PERIOD - PERIOD / 8);
    localparam logic [CW-1:0] PHI_C   = CW'(PERIOD + PERIOD / 8);
    localparam logic [CW-1:0] MINW_C  = CW'(MINW);
    localparam logic [CW-1:0] MAXW_C  = CW'(MAXW);
    localparam logic [CW-1:0] LOSTM_C = CW'(LOST - 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t        state, state_nxt;
    logic          s1, s2, s3, rise, fall;
    logic [CW-1:0] cnt, width_r, wsel;
    logic          timeout, latch_w, eval, lost;
    logic          per_ok, wid_lo, wid_hi, frame_ok;
    logic [NW-1:0] num, rem, dsr;
    logic [5:0]    q;
    logic [2:0]    step;
    logic          busy, ge, done;

    // Two-flop synchronizer followed by a registered edge detector
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= pwm_in;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
            fall <= ~s2 & s3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    assign timeout = (cnt == LOSTM_C);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (rise) state_nxt = HIGH;
            HIGH: begin
                if (fall)         state_nxt = LOW;
                else if (timeout) state_nxt = IDLE;
            end
            LOW: begin
                if (rise)         state_nxt = HIGH;
                else if (timeout) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        latch_w = (state == HIGH) && fall;
        eval    = (state == LOW) && rise;
        lost    = timeout && (((state == HIGH) && !fall) || ((state == LOW) && !rise));
    end

    // The rise cycle itself is count 1, so at the next rise cnt is the full period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            width_r <= '0;
        end else begin
            if (rise && state != HIGH) cnt <= CW'(1);
            else if (state == IDLE)    cnt <= '0;
            else                       cnt <= cnt + CW'(1);
            if (latch_w) width_r <= cnt;
        end
    end

    always_comb begin
        per_ok = (cnt >= PLO_C) && (cnt <= PHI_C);
        wid_lo = (width_r < MINW_C);
        wid_hi = (width_r > MAXW_C);
`ifdef SERVO_DEC_CLAMP_EN
        frame_ok = per_ok;
        wsel     = wid_lo ? MINW_C : (wid_hi ? MAXW_C : width_r);
`else
        frame_ok = per_ok && !wid_lo && !wid_hi;
        wsel     = width_r;
`endif
        num  = NW'(wsel - MINW_C) * NW'(100) + NW'(RANGE / 2);
        ge   = (rem >= dsr);
        done = busy && (step == 3'd6);
    end

    // Restoring divider: one quotient bit per cycle, MSB first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy        <= 1'b0;
            step        <= '0;
            rem         <= '0;
            dsr         <= '0;
            q           <= '0;
            duty_cycle  <= '0;
            duty_valid  <= 1'b0;
            pulse_err   <= 1'b0;
            signal_lost <= 1'b1;
        end else begin
            duty_valid <= 1'b0;
            pulse_err  <= 1'b0;
            if (eval && frame_ok) begin
                busy <= 1'b1;
                step <= '0;
                rem  <= num;
                dsr  <= NW'(RANGE) << 6;
                q    <= '0;
            end else if (busy) begin
                if (ge) rem <= rem - dsr;
                dsr  <= dsr >> 1;
                q    <= {q[4:0], ge};
                step <= step + 3'd1;
                if (done) begin
                    busy       <= 1'b0;
                    duty_cycle <= {q, ge};
                    duty_valid <= 1'b1;
                end
            end
            if (eval && !frame_ok && !done) pulse_err <= 1'b1;
            if (lost)      signal_lost <= 1'b1;
            else if (done) signal_lost <= 1'b0;
        end
    end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder with a scaled clock: PERIOD=1000, MINW=100,
// MAXW=300, LOST=2000 cycles. Honours SERVO_DEC_CLAMP_EN for the clamp cases.
module tb_servo_pwm_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       pwm_in;
    logic [6:0] duty_cycle;
    logic       duty_valid;
    logic       pulse_err;
    logic       signal_lost;

    int n_cmp = 0;
    int n_err = 0;

`ifdef SERVO_DEC_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    // Per-frame observations: strobes seen while the frame runs belong to the
    // rise that opened it, i.e. they report the previous frame.
    int dv_n, dv_at, dv_duty, pe_n, pe_at, both_n, sl10, sl11;
    int sl_a, sl_b;

    always #5 clk = ~clk;

    servo_pwm_decoder #(
        .SYS_FREQ    (1),
        .PULSE_FREQ  (1000),
        .MIN_PULSE_US(100),
        .MAX_PULSE_US(300)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pwm_in     (pwm_in),
        .duty_cycle (duty_cycle),
        .duty_valid (duty_valid),
        .pulse_err  (pulse_err),
        .signal_lost(signal_lost)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic frame(input int w, input int p);
        dv_n = 0; dv_at = -1; dv_duty = -1;
        pe_n = 0; pe_at = -1; both_n = 0;
        sl10 = -1; sl11 = -1;
        for (int i = 0; i < p; i++) begin
            pwm_in = (i < w);
            tick();
            if (duty_valid) begin
                dv_n++;
                dv_duty = duty_cycle;
                if (dv_at < 0) dv_at = i + 1;
            end
            if (pulse_err) begin
                pe_n++;
                if (pe_at < 0) pe_at = i + 1;
            end
            if (duty_valid && pulse_err) both_n++;
            if (i + 1 == 10) sl10 = signal_lost;
            if (i + 1 == 11) sl11 = signal_lost;
        end
    endtask

    task automatic expect_valid(input string tag, input int duty);
        chk({tag, "_dv_n"}, dv_n, 1);
        chk({tag, "_dv_at"}, dv_at, 11);
        chk({tag, "_duty"}, dv_duty, duty);
        chk({tag, "_pe_n"}, pe_n, 0);
    endtask

    task automatic expect_err(input string tag, input int held);
        chk({tag, "_pe_n"}, pe_n, 1);
        chk({tag, "_pe_at"}, pe_at, 4);
        chk({tag, "_dv_n"}, dv_n, 0);
        chk({tag, "_held"}, duty_cycle, held);
    endtask

    task automatic hold_for_loss(input int high_len);
        dv_n = 0; dv_duty = -1; sl_a = -1; sl_b = -1;
        pwm_in = 1'b1;
        for (int n = 1; n <= 2003; n++) begin
            tick();
            if (n == high_len) pwm_in = 1'b0;
            if (duty_valid) begin
                dv_n++;
                dv_duty = duty_cycle;
            end
            if (n == 2002) sl_a = signal_lost;
            if (n == 2003) sl_b = signal_lost;
        end
    endtask

    initial begin
        reset  = 1'b1;
        pwm_in = 1'b0;
        repeat (3) tick();
        chk("rst_duty", duty_cycle, 0);
        chk("rst_dv", duty_valid, 0);
        chk("rst_pe", pulse_err, 0);
        chk("rst_sl", signal_lost, 1);
        reset = 1'b0;
        repeat (5) tick();

        frame(200, 1000);
        chk("first_dv_n", dv_n, 0);
        chk("first_pe_n", pe_n, 0);
        frame(200, 1000);
        expect_valid("mid", 50);
        chk("mid_sl_pre", sl10, 1);
        chk("mid_sl_post", sl11, 0);

        frame(100, 1000);
        expect_valid("rep200", 50);
        frame(300, 1000);
        expect_valid("w100", 0);
        frame(101, 1000);
        expect_valid("w300", 100);
        frame(199, 1000);
        expect_valid("w101", 1);
        frame(90, 1000);
        expect_valid("w199", 50);

        frame(310, 1000);
        chk("w90_dv_n", dv_n, CLAMP ? 1 : 0);
        chk("w90_pe_n", pe_n, CLAMP ? 0 : 1);
        chk("w90_duty", duty_cycle, CLAMP ? 0 : 50);
        frame(200, 750);
        chk("w310_dv_n", dv_n, CLAMP ? 1 : 0);
        chk("w310_pe_n", pe_n, CLAMP ? 0 : 1);
        chk("w310_duty", duty_cycle, CLAMP ? 100 : 50);

        frame(200, 1150);
        expect_err("p750", CLAMP ? 100 : 50);
        frame(200, 1000);
        expect_err("p1150", CLAMP ? 100 : 50);
        frame(300, 875);
        expect_valid("p1000", 50);
        frame(100, 1125);
        expect_valid("p875", 100);
        frame(200, 1000);
        expect_valid("p1125", 0);

        hold_for_loss(200);
        chk("lo_dv_n", dv_n, 1);
        chk("lo_duty", dv_duty, 50);
        chk("lo_sl_before", sl_a, 0);
        chk("lo_sl_at", sl_b, 1);

        frame(200, 1000);
        chk("relo_first_dv", dv_n, 0);
        chk("relo_first_sl", signal_lost, 1);
        frame(200, 1000);
        expect_valid("relo", 50);
        chk("relo_sl_pre", sl10, 1);
        chk("relo_sl_post", sl11, 0);

        hold_for_loss(5000);
        chk("hi_dv_n", dv_n, 1);
        chk("hi_duty", dv_duty, 50);
        chk("hi_sl_before", sl_a, 0);
        chk("hi_sl_at", sl_b, 1);
        pwm_in = 1'b0;
        repeat (20) tick();

        frame(250, 1000);
        chk("rehi_first_dv", dv_n, 0);
        frame(250, 1000);
        expect_valid("w250", 75);
        chk("w250_sl_post", sl11, 0);
        chk("no_overlap", both_n, 0);

        // Reset while the pulse is high
        pwm_in = 1'b1;
        repeat (50) tick();
        reset = 1'b1;
        #1;
        chk("rh_duty", duty_cycle, 0);
        chk("rh_dv", duty_valid, 0);
        chk("rh_pe", pulse_err, 0);
        chk("rh_sl", signal_lost, 1);
        pwm_in = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();

        // Reset while the divider is busy on a valid frame
        frame(200, 1000);
        dv_n = 0;
        pwm_in = 1'b1;
        repeat (6) begin
            tick();
            if (duty_valid) dv_n++;
        end
        reset = 1'b1;
        #1;
        chk("rd_duty", duty_cycle, 0);
        chk("rd_dv", duty_valid, 0);
        chk("rd_sl", signal_lost, 1);
        repeat (2) tick();
        reset = 1'b0;
        pe_n = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (n == 100 - 80) pwm_in = 1'b0;
            if (duty_valid) dv_n++;
            if (pulse_err) pe_n++;
        end
        chk("rd_late_dv", dv_n, 0);
        chk("rd_late_pe", pe_n, 0);
        chk("rd_duty_after", duty_cycle, 0);
        chk("rd_sl_after", signal_lost, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
